// File: rtl/ext_stream_ctrl.sv
// ext_stream_ctrl: sequences one streamer extension job, gating exactly cfg_beats_i beats through a one-entry output slice
module ext_stream_ctrl #(
    parameter int DataWidth = 512,
    parameter int CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic [CntWidth-1:0]  cfg_beats_i,
    input  logic [7:0]           cfg_value_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DataWidth-1:0] in_bits_i,
    output logic                 ext_data_i_valid,
    input  logic                 ext_data_i_ready,
    output logic [DataWidth-1:0] ext_data_i_bits,
    input  logic                 ext_data_o_valid,
    output logic                 ext_data_o_ready,
    input  logic [DataWidth-1:0] ext_data_o_bits,
    output logic [31:0]          ext_csr_o,
    output logic                 ext_start_o,
    input  logic                 ext_busy_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DataWidth-1:0] out_bits_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CntWidth-1:0]  beat_cnt_o
);
    typedef enum logic [2:0] {IDLE, START, RUN, DRAIN, DONE} state_t;
    state_t state, state_nxt;
    logic [CntWidth-1:0] total, beat_cnt;
    logic [7:0] val;
    logic slice_full;
    logic [DataWidth-1:0] slice_data;
    logic open, accept;
    assign open = (state == RUN) && (beat_cnt != total);
    assign accept = ext_data_o_valid & ext_data_o_ready;
    assign cfg_ready_o = state == IDLE;
    assign ext_start_o = state == START;
    assign busy_o = state != IDLE;
    assign done_o = state == DONE;
    assign ext_data_i_valid = in_valid_i & open;
    assign in_ready_o = ext_data_i_ready & open;
    assign ext_data_i_bits = in_bits_i;
    assign ext_data_o_ready = open & (!slice_full | out_ready_i);
    assign out_valid_o = slice_full;
    assign out_bits_o = slice_data;
    assign ext_csr_o = {24'b0, val};
    assign beat_cnt_o = beat_cnt;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cfg_valid_i) state_nxt = (cfg_beats_i != '0) ? START : DONE;
            START:   state_nxt = RUN;
            RUN:     if (accept && (beat_cnt + CntWidth'(1) == total)) state_nxt = DRAIN;
            DRAIN:   if ((!slice_full || out_ready_i) && !ext_busy_i) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            total      <= '0;
            val        <= '0;
            beat_cnt   <= '0;
            slice_full <= 1'b0;
            slice_data <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && cfg_valid_i) begin
                total    <= cfg_beats_i;
                val      <= cfg_value_i;
                beat_cnt <= '0;
            end
            if (accept) beat_cnt <= beat_cnt + CntWidth'(1);
            slice_full <= accept | (slice_full & !out_ready_i);
            if (accept) slice_data <= ext_data_o_bits;
        end
    end
endmodule

// File: tb/tb_ext_stream_ctrl.sv
// tb_ext_stream_ctrl: directed self-checking bench for ext_stream_ctrl with a combinational byte-fill extension model
module tb_ext_stream_ctrl;
    localparam int DW = 32;
    localparam int CW = 16;
    logic clk, rst;
    logic cfg_valid, cfg_ready;
    logic [CW-1:0] cfg_beats;
    logic [7:0] cfg_value;
    logic in_valid, in_ready;
    logic [DW-1:0] in_bits;
    logic ext_i_valid, ext_i_ready;
    logic [DW-1:0] ext_i_bits;
    logic ext_o_valid, ext_o_ready;
    logic [DW-1:0] ext_o_bits;
    logic [31:0] ext_csr;
    logic ext_start, ext_busy;
    logic out_valid, out_ready;
    logic [DW-1:0] out_bits;
    logic busy, done;
    logic [CW-1:0] beat_cnt;
    int checks = 0, failures = 0;
    int in_hs = 0, out_hs = 0, done_cnt = 0, start_cnt = 0;
    int b_in, b_out, b_done, b_start;
    ext_stream_ctrl #(.DataWidth(DW), .CntWidth(CW)) dut (
        .clk_i(clk), .rst_i(rst),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
        .cfg_beats_i(cfg_beats), .cfg_value_i(cfg_value),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_bits_i(in_bits),
        .ext_data_i_valid(ext_i_valid), .ext_data_i_ready(ext_i_ready), .ext_data_i_bits(ext_i_bits),
        .ext_data_o_valid(ext_o_valid), .ext_data_o_ready(ext_o_ready), .ext_data_o_bits(ext_o_bits),
        .ext_csr_o(ext_csr), .ext_start_o(ext_start), .ext_busy_i(ext_busy),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_bits_o(out_bits),
        .busy_o(busy), .done_o(done), .beat_cnt_o(beat_cnt)
    );
    assign ext_i_ready = ext_o_ready;
    assign ext_o_valid = ext_i_valid;
    assign ext_o_bits = {4{ext_csr[7:0]}};
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (in_valid && in_ready) in_hs <= in_hs + 1;
        if (out_valid && out_ready) out_hs <= out_hs + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (ext_start) start_cnt <= start_cnt + 1;
    end
    task automatic tick();
        @(negedge clk);
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic snap();
        b_in = in_hs;
        b_out = out_hs;
        b_done = done_cnt;
        b_start = start_cnt;
    endtask
    task automatic wait_done(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask
    initial begin
        logic [3:0] pat;
        logic pv, pr, seen;
        logic [DW-1:0] pb;
        bit ok;
        pat = 4'b1001;
        rst = 1'b1; cfg_valid = 1'b0; cfg_beats = '0; cfg_value = '0;
        in_valid = 1'b0; in_bits = '0; ext_busy = 1'b0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_ext_i_valid", ext_i_valid, 0);
        chk("rst_ext_o_ready", ext_o_ready, 0);
        chk("rst_start", ext_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_bits", out_bits, 0);
        chk("rst_csr", ext_csr, 0);
        chk("rst_beat_cnt", beat_cnt, 0);
        rst = 1'b0;
        tick();
        // basic 4-beat job
        in_valid = 1'b1; in_bits = 32'h12345678; out_ready = 1'b1;
        snap();
        cfg_valid = 1'b1; cfg_beats = 4; cfg_value = 8'hA5;
        chk("basic_cfg_ready", cfg_ready, 1);
        tick(); cfg_valid = 1'b0;
        chk("basic_start", ext_start, 1);
        chk("basic_busy", busy, 1);
        chk("basic_csr", ext_csr, 32'h000000A5);
        chk("basic_cfg_ready_busy", cfg_ready, 0);
        tick();
        chk("basic_start_once", ext_start, 0);
        chk("basic_in_ready", in_ready, 1);
        chk("basic_ext_i_valid", ext_i_valid, 1);
        chk("basic_ext_i_bits", ext_i_bits, 32'h12345678);
        chk("basic_out_empty", out_valid, 0);
        for (int k = 3; k <= 6; k++) begin
            tick();
            chk("basic_out_valid", out_valid, 1);
            chk("basic_out_bits", out_bits, 32'hA5A5A5A5);
        end
        chk("basic_drain_in_ready", in_ready, 0);
        tick();
        chk("basic_done", done, 1);
        chk("basic_beat_cnt", beat_cnt, 4);
        chk("basic_out_cleared", out_valid, 0);
        tick();
        chk("basic_done_once", done, 0);
        chk("basic_idle", cfg_ready, 1);
        chk("basic_idle_busy", busy, 0);
        chk("basic_in_hs", in_hs - b_in, 4);
        chk("basic_out_hs", out_hs - b_out, 4);
        chk("basic_done_cnt", done_cnt - b_done, 1);
        chk("basic_start_cnt", start_cnt - b_start, 1);
        // backpressure with out_ready 1,0,0,1
        snap();
        cfg_valid = 1'b1; cfg_beats = 4; cfg_value = 8'h3C;
        tick(); cfg_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            out_ready = pat[i % 4];
            pv = out_valid; pb = out_bits; pr = out_ready;
            tick();
            if (pv && !pr) begin
                chk("bp_stall_valid", out_valid, 1);
                chk("bp_stall_bits", out_bits, pb);
            end
            if (out_valid) chk("bp_bits", out_bits, 32'h3C3C3C3C);
            if (done) begin
                chk("bp_out_before_done", out_hs - b_out, 4);
                seen = 1'b1;
                break;
            end
        end
        chk("bp_done_seen", seen, 1);
        out_ready = 1'b1;
        tick();
        chk("bp_done_cnt", done_cnt - b_done, 1);
        chk("bp_in_hs", in_hs - b_in, 4);
        chk("bp_out_hs", out_hs - b_out, 4);
        // zero-length job with upstream pending
        snap();
        cfg_valid = 1'b1; cfg_beats = 0; cfg_value = 8'h99;
        tick(); cfg_valid = 1'b0;
        chk("zero_done", done, 1);
        chk("zero_no_start", ext_start, 0);
        chk("zero_in_ready", in_ready, 0);
        chk("zero_busy", busy, 1);
        tick();
        chk("zero_done_once", done, 0);
        chk("zero_idle", cfg_ready, 1);
        chk("zero_start_cnt", start_cnt - b_start, 0);
        chk("zero_in_hs", in_hs - b_in, 0);
        // 2-beat job with excess upstream beats
        snap();
        cfg_valid = 1'b1; cfg_beats = 2; cfg_value = 8'h5A;
        tick(); cfg_valid = 1'b0;
        wait_done(20, ok);
        chk("excess_done_seen", ok, 1);
        tick(); tick(); tick();
        chk("excess_in_hs", in_hs - b_in, 2);
        chk("excess_out_hs", out_hs - b_out, 2);
        chk("excess_pending_valid", in_valid, 1);
        chk("excess_in_ready", in_ready, 0);
        chk("excess_beat_cnt", beat_cnt, 2);
        // busy hold-off after last beat drains
        snap();
        cfg_valid = 1'b1; cfg_beats = 1; cfg_value = 8'h11;
        tick(); cfg_valid = 1'b0;
        tick(); ext_busy = 1'b1;
        tick();
        chk("busy_drain_valid", out_valid, 1);
        chk("busy_drain_bits", out_bits, 32'h11111111);
        tick();
        chk("busy_hold1", done, 0);
        chk("busy_hold1_busy", busy, 1);
        chk("busy_hold1_empty", out_valid, 0);
        tick();
        chk("busy_hold2", done, 0);
        tick();
        chk("busy_hold3", done, 0);
        ext_busy = 1'b0;
        tick();
        chk("busy_done", done, 1);
        tick();
        chk("busy_done_once", done, 0);
        chk("busy_idle", cfg_ready, 1);
        // reset mid-job with beat_cnt=2 and slice full
        cfg_valid = 1'b1; cfg_beats = 4; cfg_value = 8'h44;
        tick(); cfg_valid = 1'b0;
        tick(); tick(); tick();
        out_ready = 1'b0;
        chk("mid_beat_cnt", beat_cnt, 2);
        chk("mid_slice_full", out_valid, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_idle", cfg_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_beat_cnt", beat_cnt, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_csr", ext_csr, 0);
        rst = 1'b0; out_ready = 1'b1;
        tick();
        snap();
        cfg_valid = 1'b1; cfg_beats = 1; cfg_value = 8'h77;
        tick(); cfg_valid = 1'b0;
        wait_done(20, ok);
        chk("post_rst_done_seen", ok, 1);
        chk("post_rst_beat_cnt", beat_cnt, 1);
        chk("post_rst_out_hs", out_hs - b_out, 1);
        chk("post_rst_in_hs", in_hs - b_in, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ext_stream_ctrl.md
# ext_stream_ctrl

Sequencer for a streamer data-path extension such as the byte-fill memset unit. It accepts a job descriptor with a beat count and a fill byte, drives the extension's CSR and start inputs, and gates the streamer-side handshake so that exactly the requested number of beats pass through the extension. It registers the extension output in a one-entry pipeline slice towards the downstream consumer, then signals completion. It sits between the streamer's extension port and the extension instance, inside the cluster data-mover path.

## Interface

Parameters:
- DataWidth, 512: stream beat width in bits; multiple of 8.
- CntWidth, 16: beat counter width; maximum job length is 2^CntWidth-1 beats.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- cfg_valid_i  in  1  job descriptor valid.
- cfg_ready_o  out  1  descriptor accepted; high only in IDLE.
- cfg_beats_i  in  CntWidth  number of beats for the job.
- cfg_value_i  in  8  fill byte forwarded to the extension CSR.
- in_valid_i / in_ready_o / in_bits_i  in/out/in  1/1/DataWidth  upstream stream from the streamer.
- ext_data_i_valid / ext_data_i_ready / ext_data_i_bits  out/in/out  1/1/DataWidth  towards the extension input.
- ext_data_o_valid / ext_data_o_ready / ext_data_o_bits  in/out/in  1/1/DataWidth  from the extension output.
- ext_csr_o  out  32  extension CSR 0, equal to {24'b0, latched value}.
- ext_start_o  out  1  one-cycle start pulse to the extension.
- ext_busy_i  in  1  extension busy.
- out_valid_o / out_ready_i / out_bits_o  out/in/out  1/1/DataWidth  registered downstream stream.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle completion pulse.
- beat_cnt_o  out  CntWidth  beats accepted into the output slice for the current job.

## Operation

- States are IDLE, START, RUN, DRAIN and DONE.
- **IDLE**
  - cfg_ready_o=1.
  - When cfg_valid_i=1, latch cfg_beats_i into `total` and cfg_value_i into `val`, and clear beat_cnt.
  - If cfg_beats_i≠0, go to START. If cfg_beats_i=0, go to DONE; no ext_start_o pulse and no beats are passed.
- **START**
  - ext_start_o=1 for exactly one cycle, then go to RUN.
- **RUN**
  - Define `open` = (beat_cnt≠total).
  - Forwarding to the extension input:
    - ext_data_i_valid = in_valid_i & open.
    - in_ready_o = ext_data_i_ready & open.
    - ext_data_i_bits = in_bits_i.
  - ext_data_o_ready = open & (!slice_full | out_ready_i).
  - Accept event: ext_data_o_valid & ext_data_o_ready. On an accept, load the slice with ext_data_o_bits and increment beat_cnt.
  - On the accept that makes beat_cnt==total, go to DRAIN.
- **DRAIN**
  - All handshakes into the block are held low: in_ready_o, ext_data_i_valid and ext_data_o_ready are 0.
  - Go to DONE when the slice is empty (or empties this cycle) and ext_busy_i=0.
- **DONE**
  - done_o=1 for one cycle, then go to IDLE.
- **Output slice**
  - out_valid_o = slice_full and out_bits_o = slice data.
  - The slice clears on out_ready_i when no new beat is loaded in the same cycle.
  - A simultaneous load and drain keeps the slice full with the new data, giving a throughput of 1 beat/cycle.
- **CSR value**
  - ext_csr_o holds the latched value from the cycle after cfg accept until the next accept.
- **Counter**
  - beat_cnt is CntWidth bits and never wraps, because it stops at total.
  - beat_cnt_o holds its final value through IDLE until the next accept.
- **Excess input**
  - Upstream beats beyond total stay unaccepted (in_ready_o=0) and remain pending for the next job.
- **Reset**
  - In any state, including mid-RUN, reset clears the FSM to IDLE, empties the slice, and zeroes the count and latches.
  - A beat held in the slice at reset is discarded.

## Timing

- Reset values:
  - cfg_ready_o=1 (IDLE).
  - 0: in_ready_o, ext_data_i_valid, ext_data_o_ready, ext_start_o, busy_o, done_o, out_valid_o.
  - 0: out_bits_o, ext_csr_o, beat_cnt_o.
- Cfg accepted at cycle T:
  - busy_o=1 from T+1.
  - ext_start_o=1 at T+1.
  - RUN begins at T+2, the first cycle in which a beat can be accepted.
- Latency: a beat accepted from the extension at cycle C appears on out_valid_o at C+1.
- Completion:
  - The last beat is accepted at L.
  - Earliest cycles with out_ready_i=1 and ext_busy_i=0: L+1 is DRAIN with out_valid_o=1, the slice drains that cycle, L+2 is DONE with done_o=1, and L+3 is IDLE.
- Zero-length job: accept at T, done_o at T+1, IDLE at T+2.
- The extension may be combinational; the controller adds no combinational path from out_ready_i to in_ready_o outside RUN.
- Downstream stall: out_valid_o and out_bits_o must stay stable while out_ready_i=0.

## Test plan

- **Reset:** assert rst_i for 2 cycles. Required: every output at its reset value, cfg_ready_o=1.
- **Basic job:** cfg_beats=4, cfg_value=8'hA5, upstream always valid, downstream always ready.
  - ext_start_o at T+1 and ext_csr_o=32'h000000A5.
  - 4 beats of all-A5 on out_bits_o at consecutive cycles T+3 to T+6.
  - done_o at T+7, beat_cnt_o=4.
- **Backpressure:** same 4-beat job with out_ready_i toggling 1,0,0,1.
  - out_bits_o stable during stalls; no beat lost or duplicated.
  - done_o exactly once, after the 4th output handshake.
- **Zero-length and excess input:** first, cfg_beats=0.
  - done_o at T+1, no ext_start_o, in_ready_o stays 0.
  - Then cfg_beats=2 with 5 upstream beats pending: exactly 2 are accepted and 3 remain with in_valid_i=1, in_ready_o=0.
- **Busy hold-off:** hold ext_busy_i=1 for 3 cycles after the last beat drains. Required: DONE is delayed until ext_busy_i falls, and done_o follows one cycle later.
- **Reset mid-job:** assert rst_i during RUN with beat_cnt=2 and the slice full.
  - Next cycle: IDLE, out_valid_o=0, beat_cnt_o=0.
  - A new 1-beat job then completes normally.
